// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bus for pipe_stage_reg.
// master drives the upstream slot and the stall/flush controls; slave is the register stage.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int BCNT_W = 16
);
  logic                           in_valid;
  logic [CTRL_W-1:0]              in_ctrl;
  logic [DATA_W-1:0]              in_data;
  logic                           stall;
  logic                           flush;
  logic                           out_valid;
  logic [CTRL_W-1:0]              out_ctrl;
  logic [DATA_W-1:0]              out_data;
  logic [$clog2(DEPTH+1)-1:0]     occupancy;
  logic [BCNT_W-1:0]              bubble_cnt;

  modport master (
    output in_valid, in_ctrl, in_data, stall, flush,
    input  out_valid, out_ctrl, out_data, occupancy, bubble_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, stall, flush,
    output out_valid, out_ctrl, out_data, occupancy, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-deep pipeline stage register with valid bits, stall/flush, control gating,
// occupancy tracking and a saturating output-bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int BCNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic              vld_p  [DEPTH];
  logic [CTRL_W-1:0] ctrl_p [DEPTH];
  logic [DATA_W-1:0] data_p [DEPTH];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_next;
  logic [BCNT_W-1:0] bcnt_q;
  logic              bubble_edge;

  function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // On an advance one slot enters at the head and one leaves at the tail.
  always_comb begin
    occ_next = occ_q + OCC_W'(bus.in_valid) - OCC_W'(vld_p[DEPTH-1]);
  end

  // Any edge that is not a pure stall counts as a bubble when the output slot is empty.
  assign bubble_edge = (!bus.stall || bus.flush) && !vld_p[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_p[k]  <= 1'b0;
        ctrl_p[k] <= '0;
        data_p[k] <= '0;
      end
      occ_q  <= '0;
      bcnt_q <= '0;
    end else begin
      if (bubble_edge) bcnt_q <= sat_inc(bcnt_q);
      if (bus.flush) begin
        // Payload is left in place; only the slot state is killed.
        for (int k = 0; k < DEPTH; k++) begin
          vld_p[k]  <= 1'b0;
          ctrl_p[k] <= '0;
        end
        occ_q <= '0;
      end else if (!bus.stall) begin
        vld_p[0]  <= bus.in_valid;
        ctrl_p[0] <= bus.in_valid ? bus.in_ctrl : '0;
        data_p[0] <= bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
          vld_p[k]  <= vld_p[k-1];
          ctrl_p[k] <= ctrl_p[k-1];
          data_p[k] <= data_p[k-1];
        end
        occ_q <= occ_next;
      end
    end
  end

  assign bus.out_valid  = vld_p[DEPTH-1];
  assign bus.out_ctrl   = ctrl_p[DEPTH-1];
  assign bus.out_data   = data_p[DEPTH-1];
  assign bus.occupancy  = occ_q;
  assign bus.bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 2/3/1) share one stimulus stream and are
// checked every cycle against a history-of-advances reference model.
module tb_pipe_stage_reg;
  localparam int DW = 96;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2), .BCNT_W(16)) ba ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3), .BCNT_W(4))  bb ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .BCNT_W(4))  bc ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2), .BCNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3), .BCNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bb));
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .BCNT_W(4))  dut_c (.clk(clk), .rst(rst), .bus(bc));

  // Reference model: every advance edge appends the offered slot to a history, tagged
  // with the flush epoch it entered in. The output of a DEPTH-d pipe is the slot appended
  // d advances ago; it is live only if no flush has happened since it entered.
  typedef struct {
    bit          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    int          ep;
  } slot_t;

  slot_t  hist[$];
  int     epoch;
  longint bub  [3];
  longint bmax [3] = '{65535, 15, 15};
  int     depth[3] = '{2, 3, 1};

  int vectors     = 0;
  int miscompares = 0;

  function automatic void model_out(input int dp, output bit v, output logic [CW-1:0] c,
                                    output logic [DW-1:0] d, output int occ);
    int n = hist.size();
    v = 1'b0; c = '0; d = '0; occ = 0;
    if (n >= dp) begin
      v = hist[n-dp].v && (hist[n-dp].ep == epoch);
      c = v ? hist[n-dp].c : '0;
      d = hist[n-dp].d;
    end
    for (int i = 1; i <= dp && i <= n; i++)
      if (hist[n-i].v && hist[n-i].ep == epoch) occ++;
  endfunction

  task automatic model_reset();
    hist.delete();
    epoch = 0;
    for (int k = 0; k < 3; k++) bub[k] = 0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit v; logic [CW-1:0] c; logic [DW-1:0] d; int occ;
    model_out(depth[0], v, c, d, occ);
    chk("A.out_valid", 128'(ba.out_valid), 128'(v));
    chk("A.out_ctrl",  128'(ba.out_ctrl),  128'(c));
    chk("A.out_data",  128'(ba.out_data),  128'(d));
    chk("A.occupancy", 128'(ba.occupancy), 128'(occ));
    chk("A.bubble_cnt",128'(ba.bubble_cnt),128'(bub[0]));
    model_out(depth[1], v, c, d, occ);
    chk("B.out_valid", 128'(bb.out_valid), 128'(v));
    chk("B.out_ctrl",  128'(bb.out_ctrl),  128'(c));
    chk("B.out_data",  128'(bb.out_data),  128'(d));
    chk("B.occupancy", 128'(bb.occupancy), 128'(occ));
    chk("B.bubble_cnt",128'(bb.bubble_cnt),128'(bub[1]));
    model_out(depth[2], v, c, d, occ);
    chk("C.out_valid", 128'(bc.out_valid), 128'(v));
    chk("C.out_ctrl",  128'(bc.out_ctrl),  128'(c));
    chk("C.out_data",  128'(bc.out_data),  128'(d));
    chk("C.occupancy", 128'(bc.occupancy), 128'(occ));
    chk("C.bubble_cnt",128'(bc.bubble_cnt),128'(bub[2]));
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit s, input bit f);
    ba.in_valid = v; ba.in_ctrl = c; ba.in_data = d; ba.stall = s; ba.flush = f;
    bb.in_valid = v; bb.in_ctrl = c; bb.in_data = d; bb.stall = s; bb.flush = f;
    bc.in_valid = v; bc.in_ctrl = c; bc.in_data = d; bc.stall = s; bc.flush = f;
  endtask

  // One clock edge: drive, update the model from the pre-edge view, then check.
  task automatic step(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input bit s, input bit f);
    bit ov; logic [CW-1:0] oc; logic [DW-1:0] od; int oo;
    slot_t e;
    drive(v, c, d, s, f);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      model_out(depth[k], ov, oc, od, oo);
      if ((!s || f) && !ov && bub[k] < bmax[k]) bub[k]++;
    end
    if (f) epoch++;
    else if (!s) begin
      e.v = v; e.c = c; e.d = d; e.ep = epoch;
      hist.push_back(e);
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  logic [DW-1:0] saved;

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    model_reset();
    #1 rst = 1'b1;
    #1 check_all();
    #1 rst = 1'b0;

    // single valid slot: latency and early bubbles
    step(1'b1, 8'h15, 96'hA5, 1'b0, 1'b0);
    chk("C.first_ctrl", 128'(bc.out_ctrl), 128'h15);
    step(1'b0, 8'h00, 96'h0, 1'b0, 1'b0);
    chk("A.lat_valid", 128'(ba.out_valid), 128'd1);
    chk("A.lat_ctrl",  128'(ba.out_ctrl),  128'h15);
    chk("A.lat_data",  128'(ba.out_data),  128'hA5);
    chk("A.bub_after2",128'(ba.bubble_cnt),128'd2);
    idle(3);

    // stream with a one-cycle stall after the second input
    step(1'b1, 8'h01, 96'h101, 1'b0, 1'b0);
    step(1'b1, 8'h02, 96'h102, 1'b0, 1'b0);
    chk("A.occ_peak", 128'(ba.occupancy), 128'd2);
    step(1'b1, 8'h03, 96'h103, 1'b1, 1'b0);
    step(1'b1, 8'h03, 96'h103, 1'b0, 1'b0);
    idle(3);

    // full DEPTH=3 pipe, flush and stall together with a valid incoming slot
    step(1'b1, 8'h11, 96'h211, 1'b0, 1'b0);
    step(1'b1, 8'h12, 96'h212, 1'b0, 1'b0);
    step(1'b1, 8'h13, 96'h213, 1'b0, 1'b0);
    chk("B.occ_full", 128'(bb.occupancy), 128'd3);
    saved = bb.out_data;
    step(1'b1, 8'h7E, 96'h7E7E, 1'b1, 1'b1);
    chk("B.flush_valid", 128'(bb.out_valid), 128'd0);
    chk("B.flush_ctrl",  128'(bb.out_ctrl),  128'd0);
    chk("B.flush_occ",   128'(bb.occupancy), 128'd0);
    chk("B.flush_data",  128'(bb.out_data),  128'(saved));
    idle(4);

    // invalid slot with live-looking control is gated
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hFF, 96'hFFFF, 1'b0, 1'b0);
      chk("C.gated_ctrl", 128'(bc.out_ctrl), 128'd0);
    end

    // bubble counter saturation on the 4-bit instances
    async_reset();
    idle(20);
    chk("B.bub_sat", 128'(bb.bubble_cnt), 128'd15);
    chk("C.bub_sat", 128'(bc.bubble_cnt), 128'd15);
    chk("A.bub_20",  128'(ba.bubble_cnt), 128'd20);

    // async reset while DEPTH=2 pipe is full, then recovery
    step(1'b1, 8'h21, 96'h321, 1'b0, 1'b0);
    step(1'b1, 8'h22, 96'h322, 1'b0, 1'b0);
    chk("A.occ_before_rst", 128'(ba.occupancy), 128'd2);
    async_reset();
    chk("A.rst_valid", 128'(ba.out_valid), 128'd0);
    step(1'b1, 8'h3C, 96'h33C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 96'h0,   1'b0, 1'b0);
    chk("A.post_rst_ctrl", 128'(ba.out_ctrl), 128'h3C);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom, $urandom},
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
      if ($urandom_range(0, 79) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
